// File: rtl/nano6502_io_pkg.sv
// Shared constants for the nano6502 IO page: bank numbers and the register map of the
// interrupt controller bank, used by the address decoder and firmware header generation.
package nano6502_io_pkg;

  localparam logic [15:0] IO_PAGE_BASE = 16'hFE00;
  localparam logic [7:0]  IRQ_BANK     = 8'h09;

  typedef enum logic [2:0] {
    IRQ_STATUS = 3'd0,
    IRQ_MASK   = 3'd1,
    IRQ_MODE   = 3'd2,
    IRQ_RAW    = 3'd3,
    IRQ_VECTOR = 3'd4,
    IRQ_CTRL   = 3'd5,
    IRQ_SWSET  = 3'd6
  } irq_reg_e;

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt source line: multi-flop synchronizer followed by a history flop
// so the caller can detect a rising edge on the synchronized level.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic src_i,
  output logic sync_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;

  // prev always follows sync, independent of the latch mode chosen by the parent
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], src_i};
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = chain_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller for IO bank 0x09: per-source level/edge latching, masking,
// lowest-index priority vector and a registered CPU IRQ request.
module irq_controller
  import nano6502_io_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               R_W_n,
  input  logic [2:0]         reg_addr_i,
  input  logic [2:0]         reg_addr_r_i,
  input  logic [7:0]         data_i,
  input  logic               irq_cs,
  output logic [7:0]         data_o,
  input  logic [NUM_SRC-1:0] irq_src_i,
  output logic               irq_o
);

  localparam logic [7:0] SRC_MASK = 8'((9'd1 << NUM_SRC) - 9'd1);

  logic [NUM_SRC-1:0] sync;
  logic [NUM_SRC-1:0] rise;
  logic [7:0]         sync8;
  logic [7:0]         rise8;

  logic [7:0] pending_q;
  logic [7:0] mask_q;
  logic [7:0] mode_q;
  logic       ctrl_q;

  logic       wr_en;
  logic [7:0] set_vec;
  logic [7:0] clr_vec;
  logic [7:0] pending_d;
  logic [7:0] active;
  logic [2:0] vec_idx;
  logic [7:0] vector;
  logic [7:0] rd_data;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .src_i  (irq_src_i[i]),
      .sync_o (sync[i]),
      .rise_o (rise[i])
    );
  end

  assign sync8 = 8'(sync);
  assign rise8 = 8'(rise);
  assign wr_en = irq_cs & ~R_W_n;

  // A hardware or software set in the same cycle as a W1C wins over the clear
  always_comb begin
    set_vec = (mode_q & rise8) | (~mode_q & sync8);
    clr_vec = 8'h00;
    if (wr_en && reg_addr_i == IRQ_SWSET) set_vec = set_vec | data_i;
    if (wr_en && reg_addr_i == IRQ_STATUS) clr_vec = data_i;
    pending_d = ((pending_q & ~clr_vec) | set_vec) & SRC_MASK;
  end

  always_comb begin
    active  = pending_q & mask_q;
    vec_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) vec_idx = 3'(i);
    end
    vector = (|active) ? {1'b1, 4'b0000, vec_idx} : 8'h00;
  end

  always_comb begin
    case (irq_reg_e'(reg_addr_r_i))
      IRQ_STATUS: rd_data = pending_q;
      IRQ_MASK:   rd_data = mask_q;
      IRQ_MODE:   rd_data = mode_q;
      IRQ_RAW:    rd_data = sync8;
      IRQ_VECTOR: rd_data = vector;
      IRQ_CTRL:   rd_data = {7'b0000000, ctrl_q};
      default:    rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending_q <= 8'h00;
      mask_q    <= 8'h00;
      mode_q    <= 8'h00;
      ctrl_q    <= 1'b0;
      data_o    <= 8'h00;
      irq_o     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (wr_en) begin
        case (irq_reg_e'(reg_addr_i))
          IRQ_MASK: mask_q <= data_i & SRC_MASK;
          IRQ_MODE: mode_q <= data_i & SRC_MASK;
          IRQ_CTRL: ctrl_q <= data_i[0];
          default:  ;
        endcase
      end
      data_o <= rd_data;
      irq_o  <= ctrl_q & (|active);
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Randomized and directed bench for irq_controller; a reference model predicts data_o
// and irq_o each cycle into a scoreboard that a negedge monitor drains.
module tb_irq_controller;

  localparam int NSRC = 8;
  localparam int SS   = 2;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       R_W_n = 1'b1;
  logic [2:0] reg_addr_i = 3'd0;
  logic [2:0] reg_addr_r_i = 3'd0;
  logic [7:0] data_i = 8'h00;
  logic       irq_cs = 1'b0;
  logic [7:0] data_o;
  logic [7:0] irq_src_i = 8'h00;
  logic       irq_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       irq;
  } sb_entry_t;
  sb_entry_t sb_q[$];

  logic [7:0] m_pend, m_mask, m_mode;
  logic       m_ctrl;
  logic [7:0] m_hist [SS+1];

  irq_controller #(.NUM_SRC(NSRC), .SYNC_STAGES(SS)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .R_W_n       (R_W_n),
    .reg_addr_i  (reg_addr_i),
    .reg_addr_r_i(reg_addr_r_i),
    .data_i      (data_i),
    .irq_cs      (irq_cs),
    .data_o      (data_o),
    .irq_src_i   (irq_src_i),
    .irq_o       (irq_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] ref_vector(input logic [7:0] p, input logic [7:0] m);
    logic [7:0] v;
    logic       found;
    v = 8'h00;
    found = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (!found && p[i] && m[i]) begin
        v = {5'b10000, 3'(i)};
        found = 1'b1;
      end
    end
    return v;
  endfunction

  task automatic check_value(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sync is the source line delayed by SS samples, prev one more
  always @(posedge clk_i) begin
    logic [7:0] sync_v, prev_v, set_v, clr_v, rd_v;
    if (!rst_n_i) begin
      m_pend = 8'h00; m_mask = 8'h00; m_mode = 8'h00; m_ctrl = 1'b0;
      for (int i = 0; i <= SS; i++) m_hist[i] = 8'h00;
    end else begin
      sync_v = m_hist[SS-1];
      prev_v = m_hist[SS];
      case (reg_addr_r_i)
        3'd0: rd_v = m_pend;
        3'd1: rd_v = m_mask;
        3'd2: rd_v = m_mode;
        3'd3: rd_v = sync_v;
        3'd4: rd_v = ref_vector(m_pend, m_mask);
        3'd5: rd_v = {7'd0, m_ctrl};
        default: rd_v = 8'h00;
      endcase
      sb_q.push_back('{data: rd_v, irq: m_ctrl && ((m_pend & m_mask) != 8'h00)});
      set_v = 8'h00;
      clr_v = 8'h00;
      for (int i = 0; i < NSRC; i++) begin
        if (m_mode[i]) set_v[i] = sync_v[i] && !prev_v[i];
        else           set_v[i] = sync_v[i];
      end
      if (irq_cs && !R_W_n) begin
        case (reg_addr_i)
          3'd0: clr_v = data_i;
          3'd1: m_mask = data_i;
          3'd2: m_mode = data_i;
          3'd5: m_ctrl = data_i[0];
          3'd6: set_v = set_v | data_i;
          default: ;
        endcase
      end
      m_pend = (m_pend & ~clr_v) | set_v;
      for (int i = SS; i >= 1; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = irq_src_i;
    end
  end

  always @(negedge clk_i) begin
    sb_entry_t e;
    if (rst_n_i && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_value("sb_irq", {7'd0, irq_o}, {7'd0, e.irq});
      check_value("sb_data", data_o, e.data);
    end
  end

  task automatic idle(input int n);
    irq_cs = 1'b0;
    R_W_n  = 1'b1;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic apply_stimulus(input logic [2:0] waddr, input logic [7:0] wdata);
    irq_cs     = 1'b1;
    R_W_n      = 1'b0;
    reg_addr_i = waddr;
    data_i     = wdata;
    @(negedge clk_i);
    irq_cs = 1'b0;
    R_W_n  = 1'b1;
  endtask

  task automatic check_output(input string name, input logic [2:0] raddr, input logic [7:0] exp);
    reg_addr_r_i = raddr;
    idle(1);
    check_value(name, data_o, exp);
  endtask

  task automatic check_irq(input string name, input logic exp);
    check_value(name, {7'd0, irq_o}, {7'd0, exp});
  endtask

  task automatic do_reset();
    rst_n_i   = 1'b0;
    sb_q.delete();
    irq_src_i = 8'h00;
    idle(2);
    rst_n_i = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [7:0] flip;
    @(negedge clk_i);
    do_reset();

    $display("[TB] reset defaults and level-mode latency");
    for (int a = 0; a < 8; a++) check_output($sformatf("reset_reg%0d", a), 3'(a), 8'h00);
    check_irq("reset_irq", 1'b0);
    apply_stimulus(3'd1, 8'hFF);
    apply_stimulus(3'd5, 8'h01);
    irq_src_i = 8'h01;
    n = 0;
    while (!irq_o && n < SS + 2) begin
      @(negedge clk_i);
      n++;
    end
    check_irq("t1_level_irq", 1'b1);

    $display("[TB] edge latch");
    do_reset();
    apply_stimulus(3'd2, 8'h04);
    apply_stimulus(3'd1, 8'h04);
    apply_stimulus(3'd5, 8'h01);
    irq_src_i = 8'h04;
    @(negedge clk_i);
    irq_src_i = 8'h00;
    idle(SS + 2);
    check_output("t2_status", 3'd0, 8'h04);
    check_output("t2_vector", 3'd4, 8'h82);
    check_irq("t2_irq", 1'b1);
    apply_stimulus(3'd0, 8'h04);
    check_irq("t2_irq_hold", 1'b1);
    check_output("t2_status_clr", 3'd0, 8'h00);
    check_irq("t2_irq_clr", 1'b0);

    $display("[TB] level hold");
    do_reset();
    irq_src_i = 8'h20;
    idle(SS + 2);
    apply_stimulus(3'd0, 8'h20);
    check_output("t3_level_hold", 3'd0, 8'h20);
    irq_src_i = 8'h00;
    idle(SS + 1);
    apply_stimulus(3'd0, 8'h20);
    check_output("t3_cleared", 3'd0, 8'h00);

    $display("[TB] priority and mask");
    do_reset();
    apply_stimulus(3'd6, 8'h0A);
    apply_stimulus(3'd1, 8'h0A);
    apply_stimulus(3'd5, 8'h01);
    check_output("t4_vec_81", 3'd4, 8'h81);
    apply_stimulus(3'd1, 8'h08);
    check_output("t4_vec_83", 3'd4, 8'h83);
    apply_stimulus(3'd1, 8'h00);
    check_output("t4_vec_none", 3'd4, 8'h00);
    check_irq("t4_irq_masked", 1'b0);
    check_output("t4_status_kept", 3'd0, 8'h0A);

    $display("[TB] set/clear collision and software set");
    do_reset();
    apply_stimulus(3'd2, 8'h02);
    apply_stimulus(3'd6, 8'h02);
    irq_src_i = 8'h02;
    idle(SS);
    apply_stimulus(3'd0, 8'h02);
    check_output("t5_collision", 3'd0, 8'h02);
    apply_stimulus(3'd0, 8'h02);
    apply_stimulus(3'd6, 8'h80);
    check_output("t5_swset", 3'd0, 8'h80);

    $display("[TB] asynchronous reset");
    do_reset();
    apply_stimulus(3'd6, 8'h01);
    apply_stimulus(3'd1, 8'h01);
    apply_stimulus(3'd5, 8'h01);
    reg_addr_r_i = 3'd0;
    idle(2);
    check_irq("t6_irq_before", 1'b1);
    check_value("t6_status_before", data_o, 8'h01);
    #2;
    rst_n_i = 1'b0;
    sb_q.delete();
    #1;
    check_irq("t6_async_irq", 1'b0);
    check_value("t6_async_data", data_o, 8'h00);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    $display("[TB] randomized traffic");
    for (int c = 0; c < 2000; c++) begin
      flip = 8'($urandom) & 8'($urandom) & 8'($urandom);
      irq_src_i = irq_src_i ^ flip;
      reg_addr_r_i = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 2) == 0) begin
        apply_stimulus(3'($urandom_range(0, 7)), 8'($urandom));
      end else begin
        idle(1);
      end
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
